// File: rtl/rot_search.sv
// rot_search: inverse barrel rotation, finds smallest k with rot(in,k)==target.
// Optional abort input enabled by defining ROT_SEARCH_ABORT_EN.
package rot_search_pkg;
    function automatic int log2c(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

module rot_search
    import rot_search_pkg::*;
#(
    parameter int N = 8,
    parameter int DIR = 0,
    localparam int W = log2c(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [N-1:0] in,
    input  logic [N-1:0] target,
`ifdef ROT_SEARCH_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [W-1:0] rot
);

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    localparam logic [W-1:0] K_MAX = W'(N - 1);

    state_t       state;
    logic [N-1:0] sh;
    logic [N-1:0] tg;
    logic [W-1:0] k;

    function automatic logic [N-1:0] rot1(input logic [N-1:0] v);
        if (DIR == 0) return {v[N-2:0], v[N-1]};
        else          return {v[0], v[N-1:1]};
    endfunction

    // Search FSM: one candidate rotation compared per clock, outputs registered
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            found <= 1'b0;
            rot   <= '0;
            k     <= '0;
            sh    <= '0;
            tg    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh    <= in;
                        tg    <= target;
                        k     <= '0;
                        found <= 1'b0;
                        rot   <= '0;
                        busy  <= 1'b1;
                        state <= SEARCH;
                    end
                end
                SEARCH: begin
`ifdef ROT_SEARCH_ABORT_EN
                    if (abort) begin
                        found <= 1'b0;
                        rot   <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else
`endif
                    if (sh == tg) begin
                        found <= 1'b1;
                        rot   <= k;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else if (k == K_MAX) begin
                        found <= 1'b0;
                        rot   <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        sh <= rot1(sh);
                        k  <= k + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
